seq_divider: RTL and testbench

//   Multi-cycle signed restoring divider in the datapath ALU.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared datapath constants for the sequential signed divider.
package seq_divider_pkg;

    // Operand width; the divider result is twice this wide.
    localparam int DATA_WIDTH = 32;

    // Divider control states. Four states fit a 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [DATA_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step on unsigned magnitudes.
// The {rem, quo} pair shifts left by one, then the divisor is trial-subtracted
// from the shifted remainder. The quotient bit shifted in is 1 when the trial
// does not go negative.
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] quo,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] next_rem,
    output logic [DW-1:0] next_quo
);

    // Trial subtraction carries one extra bit so its sign is visible.
    logic [DW:0] trial;
    logic        fits;

    // Shift, trial-subtract and restore when the trial goes negative.
    always_comb begin
        trial    = {rem, quo[DW-1]} - {1'b0, divisor};
        fits     = ~trial[DW];
        next_rem = fits ? trial[DW-1:0] : {rem[DW-2:0], quo[DW-1]};
        next_quo = {quo[DW-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider. Produces {remainder, quotient}
// for the Z register. Truncating division: the remainder takes the sign
// of the dividend.
module seq_divider #(
    parameter int DATA_WIDTH = seq_divider_pkg::DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero,
    output logic [2*DATA_WIDTH-1:0] result
);

    import seq_divider_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    // Two's-complement magnitude. The most negative value maps to 2^(DW-1),
    // which still fits when read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    div_state_t            state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dvsr;
    logic                  neg_q;
    logic                  neg_r;

    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quo;
    logic [DATA_WIDTH-1:0] quo_fixed;
    logic [DATA_WIDTH-1:0] rem_fixed;

    div_step #(
        .DW(DATA_WIDTH)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // Sign correction applied to the unsigned magnitudes in FIX.
    always_comb begin
        quo_fixed = neg_q ? (~quo + 1'b1) : quo;
        rem_fixed = neg_r ? (~rem + 1'b1) : rem;
    end

    // Control FSM with registered outputs. IDLE and DONE accept a start
    // identically, which allows back-to-back divides.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= S_IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            result      <= {dividend, DIV0_QUOTIENT};
                        end else begin
                            state       <= S_ITER;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            count       <= '0;
                            rem         <= '0;
                            quo         <= magnitude(dividend);
                            dvsr        <= magnitude(divisor);
                            neg_q       <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                            neg_r       <= dividend[DATA_WIDTH-1];
                        end
                    end
                end
                S_ITER: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= {rem_fixed, quo_fixed};
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, multi-cycle corner sequences and
// randomized operands checked against an arithmetic reference model.
//
// Handshake: start is a level sampled on a posedge only while the divider
// is idle or done; that edge is the accepting edge. done is a one-cycle
// pulse carrying result and div_by_zero; start while busy is dropped.
module tb_seq_divider;

    import seq_divider_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int MAX_WAIT = 100;

    logic            clock;
    logic            clear;
    logic            start;
    logic [DW-1:0]   dividend;
    logic [DW-1:0]   divisor;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [2*DW-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] exp_res;
        logic            exp_dz;
    } vec_t;

    vec_t vecs[12];

    seq_divider dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic, truncating toward zero.
    function automatic logic [2*DW-1:0] model_result(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return {a, {DW{1'b1}}};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[DW-1:0], q[DW-1:0]};
    endfunction

    function automatic int model_latency(input logic [DW-1:0] b);
        return (b == '0) ? 0 : DW + 1;
    endfunction

    // ---------------- driver tasks ----------------
    // Counts edges after the current point until done is seen (#1 after edge).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", MAX_WAIT);
        end
    endtask

    // Presents operands with start for one edge (edge 0), then waits for done.
    task automatic run_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [2*DW-1:0] res, output logic dz, output int lat);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(lat);
        res = result;
        dz  = div_by_zero;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [2*DW-1:0] res;
        logic [2*DW-1:0] exp;
        logic            dz;
        int              lat;
        int              seen_done;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;

        vecs[0]  = '{32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
        vecs[1]  = '{-32'sd100,    32'd7,        64'hFFFFFFFE_FFFFFFF2, 1'b0};
        vecs[2]  = '{32'd100,      -32'sd7,      64'h00000002_FFFFFFF2, 1'b0};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
        vecs[4]  = '{32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1};
        vecs[5]  = '{32'd9,        32'd3,        64'h00000000_00000003, 1'b0};
        vecs[6]  = '{-32'sd7,      -32'sd2,      64'hFFFFFFFF_00000003, 1'b0};
        vecs[7]  = '{32'd0,        32'd5,        64'h00000000_00000000, 1'b0};
        vecs[8]  = '{32'h80000000, 32'd1,        64'h00000000_80000000, 1'b0};
        vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000000, 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 32'd0,        64'hFFFFFFFF_FFFFFFFF, 1'b1};
        vecs[11] = '{32'h80000000, 32'd7,        64'hFFFFFFFE_EDB6DB6E, 1'b0};

        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy",   busy,        0);
        check("reset_done",   done,        0);
        check("reset_dz",     div_by_zero, 0);
        check("reset_result", result,      0);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);

        // Latency profile of 100 / 7: busy after edges 0..32, done only after edge 33
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 0; k <= DW + 2; k++) begin
            check($sformatf("lat_busy_e%0d", k), busy, (k <= DW) ? 1 : 0);
            check($sformatf("lat_done_e%0d", k), done, (k == DW + 1) ? 1 : 0);
            if (k == DW + 1) check("lat_result", result, 64'h00000002_0000000E);
            @(posedge clock);
            #1;
        end
        check("lat_result_hold", result, 64'h00000002_0000000E);

        // Directed table
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, res, dz, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_dz", i),     dz,  vecs[i].exp_dz);
            check($sformatf("vec%0d_lat", i),    lat, model_latency(vecs[i].b));
        end

        // div_by_zero persists while idle; accepted non-zero start clears it,
        // while result is kept until the new one is written
        run_div(32'd5, 32'd0, res, dz, lat);
        repeat (3) @(posedge clock);
        #1;
        check("dz_held",      div_by_zero, 1);
        check("dz_done_low",  done,        0);
        @(negedge clock);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("dz_cleared_on_start", div_by_zero, 0);
        check("result_kept_on_start", result, 64'h00000005_FFFFFFFF);
        wait_done(lat);
        check("dz_then_9_3_result", result, 64'h00000000_00000003);
        check("dz_then_9_3_lat", lat, DW + 1);

        // Start while busy is ignored; start in DONE is accepted
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_done(lat);
        check("busy_start_ignored_result", result, 64'h00000002_0000000E);
        check("busy_start_ignored_lat", lat + 10, DW + 1);
        run_div(32'd50, 32'd5, res, dz, lat);
        check("done_start_result", res, 64'h00000000_0000000A);
        check("done_start_lat", lat, DW + 1);
        check("done_start_dz", dz, 0);

        // Clear mid-ITER drops everything at once and no done follows
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        check("pre_clear_busy", busy, 1);
        clear = 1'b1;
        #1;
        check("clear_busy",   busy,        0);
        check("clear_done",   done,        0);
        check("clear_result", result,      0);
        check("clear_dz",     div_by_zero, 0);
        @(negedge clock);
        clear     = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) seen_done++;
        end
        check("clear_no_done", seen_done, 0);
        run_div(32'd9, 32'd3, res, dz, lat);
        check("after_clear_result", res, 64'h00000000_00000003);
        check("after_clear_lat", lat, DW + 1);

        // Randomized operands against the reference model
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: b = 32'hFFFFFFFF;
                4: begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            exp_q.push_back(model_result(a, b));
            run_div(a, b, res, dz, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_result(%h/%h)", n, a, b), res, exp);
            check($sformatf("rnd%0d_dz", n), dz, (b == '0) ? 1 : 0);
            check($sformatf("rnd%0d_lat", n), lat, model_latency(b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
